// File: rtl/capture_sched_pkg.sv
// Shared state encoding and default sizing for the capture scheduler.
package capture_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLIGHT  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam int NUM_REQ_DEF    = 11;
   localparam int DATA_W_DEF     = 8;
   localparam int PIPE_DEPTH_DEF = 5;

   // Index width that stays legal when a count degenerates to 1.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/capture_sched_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping at NUM_REQ-1.
module rr_pick
   import capture_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = idx_width(NUM_REQ_DEF)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [IDX_W:0] sum;

   // Walk offsets from farthest to nearest so the closest hit overwrites the rest.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
         if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
         end
         if (req[sum[IDX_W-1:0]]) begin
            winner = sum[IDX_W-1:0];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/capture_sched.sv
// Round-robin launch/capture scheduler through a PIPE_DEPTH-stage flight pipeline.
// Optional parity carry/recheck with par_err output: define CAPTURE_SCHED_PARITY_EN.
module capture_sched
   import capture_sched_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [DATA_W-1:0]          din,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       busy,
   output logic [DATA_W-1:0]          dout,
   output logic [NUM_REQ-1:0]         ack
`ifdef CAPTURE_SCHED_PARITY_EN
   ,
   output logic                       par_err
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = idx_width(PIPE_DEPTH);

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_valid;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] launch;
   logic [DATA_W-1:0] stage [PIPE_DEPTH];
`ifdef CAPTURE_SCHED_PARITY_EN
   logic                  launch_par;
   logic [PIPE_DEPTH-1:0] stage_par;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // Control FSM; all outputs are registered, so ack/dout appear the cycle after CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt_idx <= '0;
         cnt     <= '0;
         launch  <= '0;
         dout    <= '0;
         ack     <= '0;
         busy    <= 1'b0;
`ifdef CAPTURE_SCHED_PARITY_EN
         launch_par <= 1'b0;
         par_err    <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef CAPTURE_SCHED_PARITY_EN
         par_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt_idx <= pick_idx;
                  launch  <= din;
                  cnt     <= CNT_W'(PIPE_DEPTH - 1);
                  busy    <= 1'b1;
                  state   <= FLIGHT;
`ifdef CAPTURE_SCHED_PARITY_EN
                  launch_par <= ^din;
`endif
               end
            end
            FLIGHT: begin
               if (cnt == '0) begin
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            CAPTURE: begin
               dout   <= stage[PIPE_DEPTH-1];
               ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
               rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
               busy   <= 1'b0;
               state  <= IDLE;
`ifdef CAPTURE_SCHED_PARITY_EN
               par_err <= ^{stage[PIPE_DEPTH-1], stage_par[PIPE_DEPTH-1]};
`endif
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Flight pipeline only moves in FLIGHT, so the word sits in the last stage at CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage[i] <= '0;
         end
`ifdef CAPTURE_SCHED_PARITY_EN
         stage_par <= '0;
`endif
      end else if (state == FLIGHT) begin
         stage[0] <= launch;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
`ifdef CAPTURE_SCHED_PARITY_EN
         stage_par[0] <= launch_par;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            stage_par[i] <= stage_par[i-1];
         end
`endif
      end
   end

endmodule

// File: tb/tb_capture_sched.sv
// Scoreboard bench for capture_sched: transaction-level round-robin model feeds an expect queue.
module tb_capture_sched;

   localparam int N  = 11;
   localparam int W  = 8;
   localparam int PD = 5;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [W-1:0]  din;
   logic [IW-1:0] gnt_idx;
   logic          busy;
   logic [W-1:0]  dout;
   logic [N-1:0]  ack;
`ifdef CAPTURE_SCHED_PARITY_EN
   logic          par_err;
`endif

   capture_sched #(
      .NUM_REQ    (N),
      .DATA_W     (W),
      .PIPE_DEPTH (PD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .din     (din),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .dout    (dout),
      .ack     (ack)
`ifdef CAPTURE_SCHED_PARITY_EN
      ,
      .par_err (par_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           idx;
      logic [W-1:0] data;
      int           at;
      int           perr;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Model state: next requester to favour, first edge a new grant may occur, current winner.
   int m_ptr  = 0;
   int m_free = 0;
   int m_cur  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // One clock of stimulus: requesters release on ack, new requests raised, model decides the next edge.
   task automatic step(input logic [N-1:0] raise, input bit drop_cur, input int dval);
      int w;
      logic [N-1:0] r;
      @(negedge clk);
      req = (req & ~ack) | raise;
      if (drop_cur && m_cur >= 0 && m_free > cyc + 1) begin
         req = req & ~(N'(1) << m_cur);
      end
      din = (dval < 0) ? W'($urandom) : W'(dval);
      if (cyc + 1 >= m_free && req != '0) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            r = req >> ((m_ptr + k) % N);
            if (w < 0 && r[0]) w = (m_ptr + k) % N;
         end
         exp_q.push_back('{idx: w, data: din, at: cyc + 1 + PD + 1, perr: 0});
         m_cur  = w;
         m_ptr  = (w + 1) % N;
         m_free = cyc + 1 + PD + 2;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, -1);
   endtask

   initial begin : monitor
      logic [W-1:0] exp_dout;
      exp_t e;
      exp_dout = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_dout = '0;
         end else if (ack != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", ack, '0);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] ack req=%0d dout=%0h cycle=%0d", e.idx, dout, cyc);
               check("ack_vector", ack, N'(1) << e.idx);
               check("ack_cycle", cyc, e.at);
               check("dout", dout, e.data);
               check("gnt_idx", gnt_idx, e.idx);
`ifdef CAPTURE_SCHED_PARITY_EN
               check("par_err", par_err, e.perr);
`endif
               exp_dout = e.data;
            end
         end else begin
            check("dout_hold", dout, exp_dout);
            if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
               check("ack_missing", ack, N'(1) << exp_q[0].idx);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : driver
      int bcount;
      rst = 1'b1;
      req = '0;
      din = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ack", ack, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_dout", dout, '0);
      check("rst_gnt_idx", gnt_idx, '0);
      #2 rst = 1'b0;

      // Single request with busy span: FLIGHT plus CAPTURE.
      step(N'(1), 1'b0, 8'hA5);
      bcount = 0;
      for (int i = 0; i < PD + 3; i++) begin
         step('0, 1'b0, -1);
         if (busy) bcount++;
      end
      check("busy_cycles", bcount, PD + 1);
      idle(2);

      // Reset in the middle of FLIGHT discards the transaction.
      step(N'(1) << 5, 1'b0, -1);
      idle(3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ack", ack, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_dout", dout, '0);
      exp_q.delete();
      req    = '0;
      m_ptr  = 0;
      m_free = 0;
      m_cur  = -1;
      @(negedge clk);
      #2 rst = 1'b0;
      idle(PD + 4);

      // All requesters held high: strict rotation 0..10,0.
      for (int i = 0; i < (N + 1) * (PD + 2); i++) step({N{1'b1}}, 1'b0, -1);
      idle(N * (PD + 2) + PD + 3);

      // Serve requester 9 so the pointer sits at 10, then 10 and 0 compete.
      step(N'(1) << 9, 1'b0, -1);
      idle(PD + 3);
      step(N'(11'h401), 1'b0, -1);
      idle(2 * (PD + 2) + 2);

      // Requester 3 withdraws two cycles into its flight.
      step(N'(1) << 3, 1'b0, -1);
      step('0, 1'b0, -1);
      step('0, 1'b1, -1);
      idle(2 * (PD + 2));

      // Randomised traffic with occasional withdrawal of the in-flight requester.
      for (int i = 0; i < 400; i++) begin
         step(N'($urandom & $urandom & $urandom), ($urandom_range(15) == 0), -1);
      end
      idle(N * (PD + 2) + PD + 3);

`ifdef CAPTURE_SCHED_PARITY_EN
      step(N'(1) << 1, 1'b0, 8'h3C);
      idle(4);
      dut.stage[2][0] = ~dut.stage[2][0];
      exp_q[exp_q.size()-1].data = 8'h3D;
      exp_q[exp_q.size()-1].perr = 1;
      idle(PD + 3);
      step(N'(1) << 2, 1'b0, 8'h3C);
      idle(PD + 3);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
